// File: rtl/ts_null_stuffer.sv
// Packet FIFO between the T2-MI TS packer and the ASI/SPI transmitter. It buffers
// whole 188-byte packets and replays them at the BYTE_TICK rate, filling gaps with null packets.
`timescale 1ns/1ps
module ts_null_stuffer #(
  parameter int FIFO_AW = 10,
  parameter int PKT_LEN = 188
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        ENA_IN,
  input  logic        PSYNC_IN,
  input  logic        BYTE_TICK,
  output logic [7:0]  DATA_OUT,
  output logic        ENA_OUT,
  output logic        PSYNC_OUT,
  output logic [15:0] null_cnt,
  output logic        overflow,
  output logic        sync_err
);

  localparam int PW = FIFO_AW + 1;
  localparam int CW = FIFO_AW - 7;
  localparam logic [7:0] SYNC_BYTE = 8'h47;
  localparam logic [7:0] LAST_IDX  = 8'(PKT_LEN - 1);

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE, SEND_PKT, SEND_NULL} state_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t CAPACITY = ptr_t'((1 << FIFO_AW) - 1);

  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    case (idx)
      8'd0:    null_byte = SYNC_BYTE;
      8'd1:    null_byte = 8'h1F;
      8'd2:    null_byte = 8'hFF;
      8'd3:    null_byte = 8'h10;
      default: null_byte = 8'hFF;
    endcase
  endfunction

  // ---------------------------------------------------------------- input side
  ptr_t          wr_ptr, commit_ptr, rd_ptr, wr_addr, used, free;
  logic [7:0]    in_cnt;
  logic          in_active, in_drop;
  logic [CW-1:0] pkt_cnt;
  logic          is_start, bad_sync, is_body, stray, has_room, wr_en, commit, release_pkt;

  assign is_start = ENA_IN && PSYNC_IN && (DATA_IN == SYNC_BYTE);
  assign bad_sync = ENA_IN && PSYNC_IN && (DATA_IN != SYNC_BYTE);
  assign is_body  = ENA_IN && !PSYNC_IN && in_active;
  assign stray    = ENA_IN && !PSYNC_IN && !in_active;

  // A new packet always restarts at commit_ptr, which also discards any aborted partial packet.
  assign used     = commit_ptr - rd_ptr;
  assign free     = CAPACITY - used;
  assign has_room = free >= ptr_t'(PKT_LEN);
  assign wr_en    = (is_start && has_room) || (is_body && !in_drop);
  assign wr_addr  = is_start ? commit_ptr : wr_ptr;
  assign commit   = is_body && !in_drop && (in_cnt == LAST_IDX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      in_cnt     <= '0;
      in_active  <= 1'b0;
      in_drop    <= 1'b0;
      overflow   <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      overflow <= is_start && !has_room;
      sync_err <= bad_sync || stray || (is_start && in_active);
      if (is_start) begin
        in_active <= 1'b1;
        in_cnt    <= 8'd1;
        in_drop   <= !has_room;
        wr_ptr    <= has_room ? commit_ptr + PTR_ONE : commit_ptr;
      end else if (is_body) begin
        if (!in_drop) wr_ptr <= wr_ptr + PTR_ONE;
        if (in_cnt == LAST_IDX) begin
          in_active <= 1'b0;
          in_cnt    <= '0;
          if (!in_drop) commit_ptr <= wr_ptr + PTR_ONE;
        end else begin
          in_cnt <= in_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pkt_cnt <= '0;
    end else begin
      case ({commit, release_pkt})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------- byte RAM
  logic [7:0] mem [0:(1 << FIFO_AW) - 1];
  logic [7:0] ram_q;
  logic       rd_en;

  // NOTE: the byte RAM and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr[FIFO_AW-1:0]] <= DATA_IN;
    if (rd_en) ram_q <= mem[rd_ptr[FIFO_AW-1:0]];
  end

  // ---------------------------------------------------------------- output side
  state_t     state, state_nxt;
  logic [7:0] out_cnt, null_q;
  logic       take_null, null_start, src_ram;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    rd_en       = 1'b0;
    take_null   = 1'b0;
    null_start  = 1'b0;
    release_pkt = 1'b0;
    if (BYTE_TICK) begin
      case (state)
        IDLE: begin
          if (pkt_cnt != '0) begin
            rd_en     = 1'b1;
            state_nxt = SEND_PKT;
          end else begin
            take_null  = 1'b1;
            null_start = 1'b1;
            state_nxt  = SEND_NULL;
          end
        end
        SEND_PKT: begin
          rd_en = 1'b1;
          if (out_cnt == LAST_IDX) begin
            release_pkt = 1'b1;
            state_nxt   = IDLE;
          end
        end
        SEND_NULL: begin
          take_null = 1'b1;
          if (out_cnt == LAST_IDX) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr    <= '0;
      out_cnt   <= '0;
      null_cnt  <= '0;
      null_q    <= '0;
      src_ram   <= 1'b0;
      ENA_OUT   <= 1'b0;
      PSYNC_OUT <= 1'b0;
    end else begin
      ENA_OUT   <= BYTE_TICK;
      PSYNC_OUT <= BYTE_TICK && (state == IDLE);
      if (BYTE_TICK) begin
        out_cnt <= (state_nxt == IDLE) ? 8'd0 : out_cnt + 8'd1;
        src_ram <= rd_en;
      end
      if (take_null)  null_q   <= null_byte(out_cnt);
      if (rd_en)      rd_ptr   <= rd_ptr + PTR_ONE;
      if (null_start) null_cnt <= null_cnt + 16'd1;
    end
  end

  // Both byte sources only update on ticks, so DATA_OUT holds between ticks.
  assign DATA_OUT = src_ram ? ram_q : null_q;

endmodule

// File: tb/tb_ts_null_stuffer.sv
// Directed bench for ts_null_stuffer: packets are written and replayed, and the output
// byte stream is compared against hand-built packet contents and null packets.
`timescale 1ns/1ps
module tb_ts_null_stuffer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  DATA_IN = '0;
  logic        ENA_IN = 1'b0;
  logic        PSYNC_IN = 1'b0;
  logic        BYTE_TICK = 1'b0;
  logic [7:0]  DATA_OUT;
  logic        ENA_OUT;
  logic        PSYNC_OUT;
  logic [15:0] null_cnt;
  logic        overflow;
  logic        sync_err;

  ts_null_stuffer #(.FIFO_AW(10), .PKT_LEN(188)) dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENA_IN(ENA_IN), .PSYNC_IN(PSYNC_IN),
    .BYTE_TICK(BYTE_TICK), .DATA_OUT(DATA_OUT), .ENA_OUT(ENA_OUT), .PSYNC_OUT(PSYNC_OUT),
    .null_cnt(null_cnt), .overflow(overflow), .sync_err(sync_err)
  );

  always #5 CLK = ~CLK;

  int         n_cmp = 0;
  int         n_err = 0;
  int         ena_err = 0;
  int         se_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] last_data = '0;
  logic [8:0] out_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] null_ref(input int k);
    case (k)
      0:       null_ref = 8'h47;
      1:       null_ref = 8'h1F;
      2:       null_ref = 8'hFF;
      3:       null_ref = 8'h10;
      default: null_ref = 8'hFF;
    endcase
  endfunction

  // id 1 gives the reference packet 47 01 00 10 00..B7.
  function automatic logic [7:0] pkt_ref(input int id, input int k);
    case (k)
      0:       pkt_ref = 8'h47;
      1:       pkt_ref = 8'(id);
      2:       pkt_ref = 8'h00;
      3:       pkt_ref = 8'h10;
      default: pkt_ref = 8'(k - 4 + 8 * (id - 1));
    endcase
  endfunction

  // One clock: drive inputs, wait for the edge, sample 1 ns later and log the output byte.
  task automatic cycle(input logic [7:0] d, input logic e, input logic p, input logic t);
    logic rst_v;
    DATA_IN = d; ENA_IN = e; PSYNC_IN = p; BYTE_TICK = t;
    rst_v = RST;
    @(posedge CLK);
    #1;
    if (rst_v) begin
      if (ENA_OUT !== 1'b0 || DATA_OUT !== 8'h00 || PSYNC_OUT !== 1'b0) ena_err++;
      last_data = 8'h00;
    end else begin
      if (sync_err === 1'b1) se_cnt++;
      if (overflow === 1'b1) ov_cnt++;
      if (ENA_OUT !== t) ena_err++;
      else if (ENA_OUT) begin
        out_q.push_back({PSYNC_OUT, DATA_OUT});
        last_data = DATA_OUT;
      end else if (DATA_OUT !== last_data || PSYNC_OUT !== 1'b0) ena_err++;
    end
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    cycle(8'h00, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    check({tag, "_data"}, 32'(DATA_OUT), 32'h0);
    check({tag, "_ena"}, 32'(ENA_OUT), 32'h0);
    check({tag, "_nullcnt"}, 32'(null_cnt), 32'h0);
    check({tag, "_flags"}, 32'({PSYNC_OUT, overflow, sync_err}), 32'h0);
    out_q.delete();
    se_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic write_bytes(input int id, input int n, input logic t);
    for (int k = 0; k < n; k++) cycle(pkt_ref(id, k), 1'b1, k == 0, t);
  endtask

  task automatic tick_n(input int n, input int every);
    for (int i = 0; i < n * every; i++) cycle(8'h00, 1'b0, 1'b0, (i % every) == 0);
  endtask

  // id 0 expects a null packet.
  task automatic check_pkt(input string tag, input int base, input int id);
    int bad = 0;
    logic [8:0] exp;
    for (int k = 0; k < 188; k++) begin
      exp = {k == 0, (id == 0) ? null_ref(k) : pkt_ref(id, k)};
      if (base + k >= out_q.size()) bad++;
      else if (out_q[base + k] !== exp) bad++;
    end
    check(tag, 32'(bad), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    // 1: idle input, tick every 4th cycle -> two null packets.
    do_reset("t1_rst");
    tick_n(376, 4);
    check("t1_count", 32'(out_q.size()), 32'd376);
    check_pkt("t1_null0", 0, 0);
    check_pkt("t1_null1", 188, 0);
    check("t1_nullcnt", 32'(null_cnt), 32'd2);
    check("t1_timing", 32'(ena_err), 32'd0);

    // 2: one packet at full rate with continuous ticks -> appears after the current null.
    do_reset("t2_rst");
    write_bytes(1, 188, 1'b1);
    tick_n(188, 1);
    check("t2_count", 32'(out_q.size()), 32'd376);
    check_pkt("t2_null", 0, 0);
    check_pkt("t2_pkt", 188, 1);
    check("t2_nullcnt", 32'(null_cnt), 32'd1);

    // 3: stray byte, resync at byte 100, bad sync byte.
    do_reset("t3_rst");
    cycle(8'h55, 1'b1, 1'b0, 1'b0);
    check("t3_stray_err", 32'(se_cnt), 32'd1);
    write_bytes(2, 100, 1'b0);
    check("t3_partial_quiet", 32'(se_cnt), 32'd1);
    write_bytes(3, 188, 1'b0);
    check("t3_resync_err", 32'(se_cnt), 32'd2);
    cycle(8'h12, 1'b1, 1'b1, 1'b0);
    check("t3_badsync_err", 32'(se_cnt), 32'd3);
    tick_n(376, 1);
    check_pkt("t3_pkt", 0, 3);
    check_pkt("t3_null", 188, 0);
    check("t3_nullcnt", 32'(null_cnt), 32'd1);

    // 4: six packets without ticks -> five stored, one overflow.
    do_reset("t4_rst");
    for (int p = 1; p <= 5; p++) write_bytes(p, 188, 1'b0);
    check("t4_no_ovf", 32'(ov_cnt), 32'd0);
    write_bytes(6, 188, 1'b0);
    check("t4_ovf", 32'(ov_cnt), 32'd1);
    tick_n(6 * 188, 1);
    for (int p = 1; p <= 5; p++) check_pkt($sformatf("t4_pkt%0d", p), (p - 1) * 188, p);
    check_pkt("t4_null", 5 * 188, 0);
    check("t4_nullcnt", 32'(null_cnt), 32'd1);

    // 5: 20 back-to-back packets; each commit lands on the last byte of the previous output.
    do_reset("t5_rst");
    for (int p = 1; p <= 20; p++) write_bytes(p, 188, 1'b1);
    tick_n(2 * 188, 1);
    check("t5_count", 32'(out_q.size()), 32'd22 * 188);
    check_pkt("t5_null_first", 0, 0);
    for (int p = 1; p <= 20; p++) check_pkt($sformatf("t5_pkt%0d", p), p * 188, p);
    check_pkt("t5_null_last", 21 * 188, 0);
    check("t5_nullcnt", 32'(null_cnt), 32'd2);

    // 6: reset in the middle of a stored packet.
    do_reset("t6_rst");
    write_bytes(9, 188, 1'b0);
    tick_n(50, 1);
    check("t6_mid_pkt", 32'(out_q.size()), 32'd50);
    RST = 1'b1;
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    RST = 1'b0;
    check("t6_data", 32'(DATA_OUT), 32'h0);
    check("t6_ena", 32'(ENA_OUT), 32'h0);
    check("t6_nullcnt0", 32'(null_cnt), 32'h0);
    out_q.delete();
    tick_n(188, 1);
    check_pkt("t6_null", 0, 0);
    check("t6_nullcnt1", 32'(null_cnt), 32'd1);
    check("t6_timing", 32'(ena_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
